// File: rtl/stm32_bus_engine_if.sv
// Signal bundle between the STM32 bus slave engine and the surrounding bus pins,
// RX FIFO, TX sample sink, register file and status sources.
interface stm32_bus_engine_if #(
    parameter int unsigned RX_CHANNELS  = 2,
    parameter int unsigned SAMPLE_BYTES = 3,
    parameter int unsigned REG_ADDR_W   = 6
);
    localparam int unsigned SAMPLE_W = SAMPLE_BYTES * 8;
    localparam int unsigned RX_W     = RX_CHANNELS * 2 * SAMPLE_W;

    logic                  DATA_SYNC;
    logic [7:0]            bus_in;
    logic [7:0]            bus_out;
    logic                  bus_oe;
    logic [RX_W-1:0]       rx_data;
    logic                  rx_empty;
    logic [3:0]            rx_active;
    logic                  rx_ready;
    logic [SAMPLE_W-1:0]   tx_i;
    logic [SAMPLE_W-1:0]   tx_q;
    logic                  tx_valid;
    logic                  reg_wr_en;
    logic [REG_ADDR_W-1:0] reg_wr_addr;
    logic [7:0]            reg_wr_data;
    logic [6:0]            status_flags;

    modport slave (
        input  DATA_SYNC, bus_in, rx_data, rx_empty, rx_active, status_flags,
        output bus_out, bus_oe, rx_ready, tx_i, tx_q, tx_valid,
               reg_wr_en, reg_wr_addr, reg_wr_data
    );

    modport master (
        output DATA_SYNC, bus_in, rx_data, rx_empty, rx_active, status_flags,
        input  bus_out, bus_oe, rx_ready, tx_i, tx_q, tx_valid,
               reg_wr_en, reg_wr_addr, reg_wr_data
    );
endinterface

// File: rtl/stm32_bus_engine.sv
// STM32 8-bit parallel-bus slave: command decode, echo, register writes, status
// readback with underrun counter, TX IQ frame capture and RX IQ frame streaming.
module stm32_bus_engine #(
    parameter int unsigned RX_CHANNELS  = 2,
    parameter int unsigned SAMPLE_BYTES = 3,
    parameter int unsigned REG_ADDR_W   = 6
) (
    input  logic              clk_in,
    input  logic              reset_in,
    stm32_bus_engine_if.slave bus
);
    localparam int unsigned SAMPLE_W = SAMPLE_BYTES * 8;
    localparam int unsigned CH_BYTES = 2 * SAMPLE_BYTES;
    localparam int unsigned TX_W     = CH_BYTES * 8;
    localparam int unsigned RX_W     = RX_CHANNELS * TX_W;
    localparam int unsigned CNT_W    = 8;

    typedef enum logic [2:0] {
        S_IDLE, S_ECHO, S_REGWR, S_STATUS, S_TXIQ, S_RXIQ
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      beat_cnt;
    logic [CNT_W-1:0]      rx_len;
    logic [RX_W-1:0]       rx_shadow;
    logic [TX_W-1:0]       tx_shift;
    logic [7:0]            echo_byte;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic                  addr_valid;
    logic [15:0]           underrun_cnt;
    logic                  sticky;

    logic [3:0]            chan_c;
    logic [CNT_W-1:0]      rx_len_c;
    logic [CNT_W-1:0]      ch_c;
    logic [CNT_W-1:0]      pos_c;
    logic [CNT_W-1:0]      sel_c;
    logic [7:0]            rx_byte_c;
    logic [TX_W-1:0]       tx_full_c;
    logic                  rx_latch_c;
    logic                  status_clear_c;

    // Frame length from the clamped channel count
    always_comb begin
        chan_c = bus.rx_active;
        if (bus.rx_active == 4'd0 || 32'(bus.rx_active) > RX_CHANNELS)
            chan_c = 4'(RX_CHANNELS);
        rx_len_c = CNT_W'(chan_c) * CNT_W'(CH_BYTES);
    end

    // Shadow byte for the current RX beat: per channel Q then I, each MSB first
    always_comb begin
        ch_c  = beat_cnt / CNT_W'(CH_BYTES);
        pos_c = beat_cnt % CNT_W'(CH_BYTES);
        if (pos_c < CNT_W'(SAMPLE_BYTES))
            sel_c = ch_c * CNT_W'(CH_BYTES) + CNT_W'(SAMPLE_BYTES - 1) - pos_c;
        else
            sel_c = ch_c * CNT_W'(CH_BYTES) + CNT_W'(SAMPLE_BYTES + CH_BYTES - 1) - pos_c;
        rx_byte_c = 8'(rx_shadow >> {sel_c, 3'b000});
    end

    always_comb begin
        tx_full_c      = {tx_shift[TX_W-9:0], bus.bus_in};
        rx_latch_c     = (bus.DATA_SYNC && bus.bus_in == 8'd4) ||
                         (!bus.DATA_SYNC && state == S_RXIQ && beat_cnt == rx_len - CNT_W'(1));
        status_clear_c = !bus.DATA_SYNC && state == S_STATUS && beat_cnt == CNT_W'(2);
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state            <= S_IDLE;
            beat_cnt         <= '0;
            rx_len           <= '0;
            rx_shadow        <= '0;
            tx_shift         <= '0;
            echo_byte        <= '0;
            wr_addr          <= '0;
            addr_valid       <= 1'b0;
            underrun_cnt     <= '0;
            sticky           <= 1'b0;
            bus.bus_out      <= '0;
            bus.bus_oe       <= 1'b0;
            bus.rx_ready     <= 1'b0;
            bus.tx_i         <= '0;
            bus.tx_q         <= '0;
            bus.tx_valid     <= 1'b0;
            bus.reg_wr_en    <= 1'b0;
            bus.reg_wr_addr  <= '0;
            bus.reg_wr_data  <= '0;
        end else begin
            bus.rx_ready  <= 1'b0;
            bus.tx_valid  <= 1'b0;
            bus.reg_wr_en <= 1'b0;
            if (bus.DATA_SYNC) begin
                // A command beat abandons whatever was in flight
                beat_cnt    <= '0;
                addr_valid  <= 1'b0;
                bus.bus_out <= 8'h00;
                bus.bus_oe  <= (bus.bus_in == 8'd2) || (bus.bus_in == 8'd4);
                case (bus.bus_in)
                    8'd0:    state <= S_ECHO;
                    8'd1:    state <= S_REGWR;
                    8'd2:    state <= S_STATUS;
                    8'd3:    state <= S_TXIQ;
                    8'd4:    state <= S_RXIQ;
                    default: state <= S_IDLE;
                endcase
            end else begin
                case (state)
                    S_ECHO: begin
                        beat_cnt <= CNT_W'(!beat_cnt[0]);
                        if (!beat_cnt[0]) begin
                            echo_byte  <= bus.bus_in;
                            bus.bus_oe <= 1'b0;
                        end else begin
                            bus.bus_out <= echo_byte;
                            bus.bus_oe  <= 1'b1;
                        end
                    end
                    S_REGWR: begin
                        if (!addr_valid) begin
                            wr_addr    <= REG_ADDR_W'(bus.bus_in);
                            addr_valid <= 1'b1;
                        end else begin
                            bus.reg_wr_en   <= 1'b1;
                            bus.reg_wr_addr <= wr_addr;
                            bus.reg_wr_data <= bus.bus_in;
                            wr_addr         <= wr_addr + REG_ADDR_W'(1);
                        end
                    end
                    S_STATUS: begin
                        case (beat_cnt)
                            CNT_W'(0): bus.bus_out <= {sticky, bus.status_flags};
                            CNT_W'(1): bus.bus_out <= underrun_cnt[15:8];
                            CNT_W'(2): bus.bus_out <= underrun_cnt[7:0];
                            default:   bus.bus_out <= 8'h00;
                        endcase
                        if (beat_cnt != CNT_W'(3))
                            beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                    S_TXIQ: begin
                        tx_shift <= tx_full_c;
                        if (beat_cnt == CNT_W'(CH_BYTES - 1)) begin
                            beat_cnt     <= '0;
                            bus.tx_q     <= tx_full_c[TX_W-1 -: SAMPLE_W];
                            bus.tx_i     <= tx_full_c[SAMPLE_W-1:0];
                            bus.tx_valid <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                    S_RXIQ: begin
                        bus.bus_out <= rx_byte_c;
                        if (rx_latch_c)
                            beat_cnt <= '0;
                        else
                            beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                    default: ;
                endcase
            end

            // Head latch at RX frame start; an empty FIFO sends zeros and counts an underrun
            if (rx_latch_c) begin
                rx_len <= rx_len_c;
                if (bus.rx_empty) begin
                    rx_shadow <= '0;
                    sticky    <= 1'b1;
                    if (underrun_cnt != 16'hFFFF)
                        underrun_cnt <= underrun_cnt + 16'd1;
                end else begin
                    rx_shadow    <= bus.rx_data;
                    bus.rx_ready <= 1'b1;
                end
            end

            // Placed last so a readback clear beats a same-edge underrun
            if (status_clear_c) begin
                underrun_cnt <= '0;
                sticky       <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stm32_bus_engine.sv
// Randomised scoreboard bench for stm32_bus_engine: stimulus tasks push per-beat
// expectations and strobe payloads; a monitor pops and compares after each edge.
module tb_stm32_bus_engine;
    localparam int unsigned RXC = 2;
    localparam int unsigned SB  = 3;
    localparam int unsigned AW  = 6;
    localparam int unsigned SW  = SB * 8;
    localparam int unsigned RXW = RXC * 2 * SW;

    typedef struct {
        bit         oe;
        bit         c_out;
        logic [7:0] out;
        bit         pop;
        bit         txv;
        bit         we;
    } exp_t;
    typedef struct { logic [SW-1:0] q; logic [SW-1:0] i; } tx_t;
    typedef struct { logic [AW-1:0] a; logic [7:0] d; } wr_t;

    logic clk = 1'b0;
    logic reset_in;
    always #5 clk = ~clk;

    stm32_bus_engine_if #(.RX_CHANNELS(RXC), .SAMPLE_BYTES(SB), .REG_ADDR_W(AW)) bus ();
    stm32_bus_engine #(.RX_CHANNELS(RXC), .SAMPLE_BYTES(SB), .REG_ADDR_W(AW)) dut (
        .clk_in  (clk),
        .reset_in(reset_in),
        .bus     (bus)
    );

    exp_t           exp_q[$];
    tx_t            tx_exp[$];
    wr_t            wr_exp[$];
    logic [RXW-1:0] env_q[$];
    logic [RXW-1:0] model_q[$];
    int             nvec = 0;
    int             nbad = 0;
    logic [15:0]    m_cnt;
    bit             m_sticky;
    bit             last_pop;
    logic [6:0]     cur_flags;
    logic [3:0]     cur_active;
    logic [7:0]     tx_pat[6];
    exp_t           mon_e;
    tx_t            mon_t;
    wr_t            mon_w;

    // FIFO environment: show-ahead head, popped on rx_ready
    always @(posedge clk)
        if (bus.rx_ready === 1'b1 && env_q.size() > 0) env_q.delete(0);

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            nvec++;
            if (bus.bus_oe !== mon_e.oe || (mon_e.c_out && bus.bus_out !== mon_e.out) ||
                bus.rx_ready !== mon_e.pop || bus.tx_valid !== mon_e.txv || bus.reg_wr_en !== mon_e.we) begin
                nbad++;
                $display("FAIL beat @%0t: got oe=%b out=%02h pop=%b txv=%b we=%b, want oe=%b out=%02h(chk=%0b) pop=%b txv=%b we=%b",
                         $time, bus.bus_oe, bus.bus_out, bus.rx_ready, bus.tx_valid, bus.reg_wr_en,
                         mon_e.oe, mon_e.out, mon_e.c_out, mon_e.pop, mon_e.txv, mon_e.we);
            end
        end
        if (bus.tx_valid === 1'b1) begin
            nvec++;
            if (tx_exp.size() == 0) begin
                nbad++;
                $display("FAIL tx_unexpected @%0t: q=%06h i=%06h, want no strobe", $time, bus.tx_q, bus.tx_i);
            end else begin
                mon_t = tx_exp.pop_front();
                if (bus.tx_q !== mon_t.q || bus.tx_i !== mon_t.i) begin
                    nbad++;
                    $display("FAIL tx_pair @%0t: q=%06h i=%06h, want q=%06h i=%06h",
                             $time, bus.tx_q, bus.tx_i, mon_t.q, mon_t.i);
                end
            end
        end
        if (bus.reg_wr_en === 1'b1) begin
            nvec++;
            if (wr_exp.size() == 0) begin
                nbad++;
                $display("FAIL wr_unexpected @%0t: addr=%02h data=%02h, want no strobe", $time, bus.reg_wr_addr, bus.reg_wr_data);
            end else begin
                mon_w = wr_exp.pop_front();
                if (bus.reg_wr_addr !== mon_w.a || bus.reg_wr_data !== mon_w.d) begin
                    nbad++;
                    $display("FAIL reg_write @%0t: addr=%02h data=%02h, want addr=%02h data=%02h",
                             $time, bus.reg_wr_addr, bus.reg_wr_data, mon_w.a, mon_w.d);
                end
            end
        end
    end

    function automatic exp_t mk(input bit oe, input bit c_out, input logic [7:0] out,
                                input bit pop, input bit txv, input bit we);
        exp_t e;
        e.oe = oe; e.c_out = c_out; e.out = out; e.pop = pop; e.txv = txv; e.we = we;
        return e;
    endfunction

    // Byte b of an RX frame built from a latched head
    function automatic logic [7:0] frame_byte(input logic [RXW-1:0] head, input int unsigned b);
        int unsigned ch, w;
        logic [SW-1:0] s;
        ch = b / (2 * SB);
        w  = b % (2 * SB);
        if (w < SB) s = SW'(head >> (ch * 2 * SW));
        else        s = SW'(head >> (ch * 2 * SW + SW));
        return 8'(s >> (8 * (SB - 1 - (w % SB))));
    endfunction

    task automatic beat(input bit rst, input bit sync, input logic [7:0] d, input exp_t e);
        @(negedge clk);
        reset_in          = rst;
        bus.DATA_SYNC     = sync;
        bus.bus_in        = d;
        bus.status_flags  = cur_flags;
        bus.rx_active     = cur_active;
        if (env_q.size() > 0) begin
            bus.rx_data  = env_q[0];
            bus.rx_empty = 1'b0;
        end else begin
            bus.rx_data  = RXW'({$urandom, $urandom, $urandom, $urandom});
            bus.rx_empty = 1'b1;
        end
        exp_q.push_back(e);
        last_pop = e.pop;
    endtask

    task automatic model_latch(output logic [RXW-1:0] v, output bit p);
        if (model_q.size() > 0) begin
            v = model_q.pop_front();
            p = 1'b1;
        end else begin
            v = '0;
            p = 1'b0;
            m_sticky = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
    endtask

    task automatic push_heads(input int k);
        logic [RXW-1:0] h;
        for (int n = 0; n < k; n++) begin
            h = RXW'({$urandom, $urandom, $urandom, $urandom});
            env_q.push_back(h);
            model_q.push_back(h);
        end
    endtask

    task automatic do_reset(input bit sync);
        beat(1'b1, sync, 8'd4, mk(0, 1, 8'h00, 0, 0, 0));
        m_cnt = '0;
        m_sticky = 1'b0;
        @(posedge clk);
        #2;
        nvec++;
        if (bus.tx_i !== '0 || bus.tx_q !== '0 || bus.reg_wr_addr !== '0 || bus.reg_wr_data !== '0) begin
            nbad++;
            $display("FAIL reset_regs: tx_i=%06h tx_q=%06h addr=%02h data=%02h, want all 0",
                     bus.tx_i, bus.tx_q, bus.reg_wr_addr, bus.reg_wr_data);
        end
    endtask

    task automatic do_echo(input int n, input bit directed);
        logic [7:0] cap, d;
        cap = 8'h00;
        beat(1'b0, 1'b1, 8'd0, mk(0, 0, 8'h00, 0, 0, 0));
        for (int j = 0; j < n; j++) begin
            d = 8'($urandom);
            if (directed) d = (j < 2) ? 8'hA5 : 8'h3C;
            if (j % 2 == 0) begin
                cap = d;
                beat(1'b0, 1'b0, d, mk(0, 0, 8'h00, 0, 0, 0));
            end else begin
                beat(1'b0, 1'b0, d, mk(1, 1, cap, 0, 0, 0));
            end
        end
    endtask

    task automatic do_regwr(input logic [7:0] a0, input int n, input bit directed);
        logic [AW-1:0] a;
        logic [7:0] d;
        wr_t w;
        beat(1'b0, 1'b1, 8'd1, mk(0, 0, 8'h00, 0, 0, 0));
        if (n == 0) return;
        beat(1'b0, 1'b0, a0, mk(0, 0, 8'h00, 0, 0, 0));
        a = AW'(a0);
        for (int j = 1; j < n; j++) begin
            d = directed ? 8'(17 * j) : 8'($urandom);
            w.a = a; w.d = d;
            wr_exp.push_back(w);
            beat(1'b0, 1'b0, d, mk(0, 0, 8'h00, 0, 0, 1));
            a = (a == AW'((1 << AW) - 1)) ? '0 : a + AW'(1);
        end
    endtask

    task automatic do_status(input int n);
        logic [7:0] b;
        beat(1'b0, 1'b1, 8'd2, mk(1, 0, 8'h00, 0, 0, 0));
        for (int j = 0; j < n; j++) begin
            cur_flags = 7'($urandom);
            case (j)
                0:       b = {m_sticky, cur_flags};
                1:       b = m_cnt[15:8];
                2:       b = m_cnt[7:0];
                default: b = 8'h00;
            endcase
            beat(1'b0, 1'b0, 8'($urandom), mk(1, 1, b, 0, 0, 0));
            if (j == 2) begin
                m_cnt = '0;
                m_sticky = 1'b0;
            end
        end
    endtask

    task automatic do_txiq(input int n, input bit directed);
        logic [7:0] bytes[2*SB];
        logic [7:0] d;
        tx_t t;
        int pos;
        beat(1'b0, 1'b1, 8'd3, mk(0, 0, 8'h00, 0, 0, 0));
        for (int j = 0; j < n; j++) begin
            pos = j % (2 * SB);
            d = directed ? tx_pat[pos] : 8'($urandom);
            bytes[pos] = d;
            if (pos == 2 * SB - 1) begin
                t.q = '0; t.i = '0;
                for (int k = 0; k < SB; k++) begin
                    t.q = (t.q << 8) | SW'(bytes[k]);
                    t.i = (t.i << 8) | SW'(bytes[SB + k]);
                end
                tx_exp.push_back(t);
                beat(1'b0, 1'b0, d, mk(0, 0, 8'h00, 0, 1, 0));
            end else begin
                beat(1'b0, 1'b0, d, mk(0, 0, 8'h00, 0, 0, 0));
            end
        end
    endtask

    task automatic do_rxiq(input logic [3:0] active, input int n);
        logic [RXW-1:0] shadow, nshadow;
        bit p;
        int unsigned c, len, pos;
        // Let a pending pop reach the FIFO before the next head latch
        if (last_pop) beat(1'b0, 1'b1, 8'hFF, mk(0, 0, 8'h00, 0, 0, 0));
        c = (active == 4'd0 || active > RXC) ? RXC : 32'(active);
        len = c * 2 * SB;
        cur_active = active;
        model_latch(shadow, p);
        beat(1'b0, 1'b1, 8'd4, mk(1, 0, 8'h00, p, 0, 0));
        pos = 0;
        for (int j = 0; j < n; j++) begin
            nshadow = shadow;
            p = 1'b0;
            if (pos == len - 1) model_latch(nshadow, p);
            beat(1'b0, 1'b0, 8'($urandom), mk(1, 1, frame_byte(shadow, pos), p, 0, 0));
            if (pos == len - 1) begin
                shadow = nshadow;
                pos = 0;
            end else begin
                pos++;
            end
        end
    endtask

    task automatic do_other(input int n);
        beat(1'b0, 1'b1, 8'($urandom_range(5, 255)), mk(0, 0, 8'h00, 0, 0, 0));
        for (int j = 0; j < n; j++)
            beat(1'b0, 1'b0, 8'($urandom), mk(0, 0, 8'h00, 0, 0, 0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [RXW-1:0] h;
        int op, n;
        reset_in = 1'b1;
        bus.DATA_SYNC = 1'b0;
        bus.bus_in = '0;
        bus.rx_data = '0;
        bus.rx_empty = 1'b1;
        bus.rx_active = 4'd1;
        bus.status_flags = '0;
        cur_flags = 7'h2A;
        cur_active = 4'd1;
        m_cnt = '0;
        m_sticky = 1'b0;
        last_pop = 1'b0;
        tx_pat[0] = 8'h01; tx_pat[1] = 8'h02; tx_pat[2] = 8'h03;
        tx_pat[3] = 8'h0A; tx_pat[4] = 8'h0B; tx_pat[5] = 8'h0C;

        do_reset(1'b0);
        do_reset(1'b1);

        do_echo(4, 1'b1);
        do_regwr(8'h3E, 4, 1'b1);
        do_txiq(2 * 2 * SB + 3, 1'b1);
        do_status(4);

        // Directed RX: one-channel frame then a two-channel frame
        h = {RXW'($urandom), 24'hABCDEF, 24'h123456};
        h[RXW-1:48] = 48'hFEDCBA987654;
        env_q.push_back(h); model_q.push_back(h);
        push_heads(1);
        do_rxiq(4'd1, 6);
        push_heads(2);
        do_rxiq(4'd2, 12);

        // Three underruns, then two status reads
        do_rxiq(4'd1, 12);
        do_status(3);
        do_status(3);

        // Reset mid-frame, then a clean restart with clamped channel count
        push_heads(2);
        do_rxiq(4'd2, 5);
        do_reset(1'b0);
        push_heads(1);
        do_rxiq(4'd0, 14);

        for (int it = 0; it < 70; it++) begin
            op = $urandom_range(0, 12);
            n  = $urandom_range(0, 20);
            push_heads($urandom_range(0, 2));
            case (op)
                0, 1:    do_echo(n, 1'b0);
                2, 3:    do_regwr(8'($urandom), n, 1'b0);
                4, 5:    do_status(n);
                6, 7:    do_txiq(n, 1'b0);
                8, 9, 10: do_rxiq(4'($urandom), n + 10);
                11:      do_other(n);
                default: do_reset(1'($urandom));
            endcase
        end

        beat(1'b0, 1'b1, 8'hFF, mk(0, 0, 8'h00, 0, 0, 0));
        repeat (4) @(negedge clk);
        nvec++;
        if (exp_q.size() != 0 || tx_exp.size() != 0 || wr_exp.size() != 0) begin
            nbad++;
            $display("FAIL drain: beats=%0d tx=%0d wr=%0d left, want 0 0 0",
                     exp_q.size(), tx_exp.size(), wr_exp.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end
endmodule
